// File: rtl/alu_rr_arbiter.sv
// rtl/alu_rr_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
module alu_rr_arbiter #(
  parameter int DATA_W  = 2,
  parameter int SEL_W   = 2,
  parameter int RES_W   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] b1,
  input  logic [SEL_W-1:0]  sel0,
  input  logic [SEL_W-1:0]  sel1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [RES_W-1:0]  result_o,
  output logic              busy_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [SEL_W-1:0]  alu_sel_o,
  input  logic [RES_W-1:0]  alu_y_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q;
  logic       ptr_q;   // last-served requester; also owner of the op in flight
  logic       win1;
  logic       launch;
  logic       capture;

  // On contention the requester that was not served last wins.
  assign win1    = req1 & (~req0 | ~ptr_q);
  assign launch  = (state_q == IDLE) & (req0 | req1);
  assign capture = (state_q == EXEC) & (cnt_q == 4'd0);
  assign busy_o  = (state_q == EXEC) | (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req0 | req1) state_d = EXEC;
      EXEC:    if (cnt_q == 4'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      ptr_q     <= 1'b1;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      result_o  <= '0;
      alu_a_o   <= '0;
      alu_b_o   <= '0;
      alu_sel_o <= '0;
    end else begin
      state_q <= state_d;
      gnt0    <= launch & ~win1;
      gnt1    <= launch & win1;
      done0   <= capture & ~ptr_q;
      done1   <= capture & ptr_q;
      if (launch) begin
        ptr_q     <= win1;
        alu_a_o   <= win1 ? a1 : a0;
        alu_b_o   <= win1 ? b1 : b0;
        alu_sel_o <= win1 ? sel1 : sel0;
        cnt_q     <= 4'(ALU_LAT - 1);
      end else if ((state_q == EXEC) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (capture) result_o <= alu_y_i;
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// tb/tb_alu_rr_arbiter.sv - scoreboard bench for alu_rr_arbiter with stub ALU Y = {A, B}
module tb_alu_rr_arbiter;

  typedef struct packed {
    logic       id;
    logic [3:0] res;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  exp_t q1[$];
  exp_t q3[$];

  // ALU_LAT = 1 instance
  logic       req0 = 0, req1 = 0;
  logic [1:0] a0 = 0, a1 = 0, b0 = 0, b1 = 0, sel0 = 0, sel1 = 0;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [3:0] result, alu_y;
  logic [1:0] alu_a, alu_b, alu_sel;
  assign alu_y = {alu_a, alu_b};

  alu_rr_arbiter #(.ALU_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1), .sel0(sel0), .sel1(sel1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result_o(result), .busy_o(busy), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .alu_sel_o(alu_sel), .alu_y_i(alu_y)
  );

  // ALU_LAT = 3 instance, only requester 1 is exercised
  logic       r3_req1 = 0;
  logic [1:0] r3_a1 = 0, r3_b1 = 0, r3_sel1 = 0;
  logic       r3_gnt0, r3_gnt1, r3_done0, r3_done1, r3_busy;
  logic [3:0] r3_result, r3_y;
  logic [1:0] r3_alu_a, r3_alu_b, r3_alu_sel;
  assign r3_y = {r3_alu_a, r3_alu_b};

  alu_rr_arbiter #(.ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req0(1'b0), .req1(r3_req1),
    .a0(2'b00), .a1(r3_a1), .b0(2'b00), .b1(r3_b1), .sel0(2'b00), .sel1(r3_sel1),
    .gnt0(r3_gnt0), .gnt1(r3_gnt1), .done0(r3_done0), .done1(r3_done1),
    .result_o(r3_result), .busy_o(r3_busy), .alu_a_o(r3_alu_a), .alu_b_o(r3_alu_b),
    .alu_sel_o(r3_alu_sel), .alu_y_i(r3_y)
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_outs", {gnt0, gnt1, done0, done1, busy, 3'b0}, 8'h00);
    chk("rst_alu", {alu_a, alu_b, alu_sel, 2'b0}, 8'h00);
    chk("rst_result", {4'h0, result}, 8'h00);
    tick();
    rst_n = 1'b1;
  endtask

  // Scoreboard monitors: pop on every done pulse, compare owner and result.
  always @(negedge clk) begin
    if (gnt0 | gnt1 | done0 | done1) begin
      chk("excl", 8'(gnt0 + gnt1 + done0 + done1), 8'd1);
    end
    if (done0 | done1) begin
      if (q1.size() == 0) begin
        chk("unexpected_done", {7'd0, done1}, 8'hff);
      end else begin
        exp_t e;
        e = q1.pop_front();
        chk("done_id", {7'd0, done1}, {7'd0, e.id});
        chk("result", {4'h0, result}, {4'h0, e.res});
      end
    end
  end

  always @(negedge clk) begin
    if (r3_done0 | r3_done1) begin
      if (q3.size() == 0) begin
        chk("lat3_unexpected_done", {7'd0, r3_done1}, 8'hff);
      end else begin
        exp_t e;
        e = q3.pop_front();
        chk("lat3_done_id", {7'd0, r3_done1}, {7'd0, e.id});
        chk("lat3_result", {4'h0, r3_result}, {4'h0, e.res});
      end
    end
  end

  initial begin
    do_reset();

    // single request on req0
    req0 = 1; a0 = 2'b01; b0 = 2'b10; sel0 = 2'b00;
    q1.push_back('{1'b0, 4'b0110});
    tick();
    chk("t1_gnt", {6'd0, gnt0, gnt1}, 8'b10);
    chk("t1_sel", {6'd0, alu_sel}, 8'h00);
    tick();
    chk("t1_done", {6'd0, done0, done1}, 8'b10);
    req0 = 0;
    tick();
    chk("t1_idle", {5'd0, busy, gnt0, done0}, 8'h00);

    // simultaneous requests straight after reset
    do_reset();
    req0 = 1; a0 = 2'b01; b0 = 2'b10; sel0 = 2'b00;
    req1 = 1; a1 = 2'b11; b1 = 2'b00; sel1 = 2'b01;
    q1.push_back('{1'b0, 4'b0110});
    q1.push_back('{1'b1, 4'b1100});
    tick();
    chk("t2_gnt0", {6'd0, gnt0, gnt1}, 8'b10);
    tick();
    req0 = 0;
    tick();
    chk("t2_no_gnt_from_done", {6'd0, gnt1, busy}, 8'h00);
    tick();
    chk("t2_gnt1", {6'd0, gnt0, gnt1}, 8'b01);
    chk("t2_alu_a", {6'd0, alu_a}, 8'h03);
    tick();
    chk("t2_done1", {6'd0, done0, done1}, 8'b01);
    req1 = 0;
    tick();

    // both held for four ops: alternate 0,1,0,1
    req0 = 1; a0 = 2'b10; b0 = 2'b01;
    req1 = 1; a1 = 2'b00; b1 = 2'b11;
    for (int i = 0; i < 4; i++) begin
      q1.push_back('{1'(i % 2), (i % 2) ? 4'b0011 : 4'b1001});
      tick();
      chk("t3_gnt", {6'd0, gnt0, gnt1}, (i % 2) ? 8'b01 : 8'b10);
      tick();
      if (i == 3) begin req0 = 0; req1 = 0; end
      tick();
    end

    // req0 held through done0 counts as a new request
    req0 = 1; a0 = 2'b11; b0 = 2'b11;
    q1.push_back('{1'b0, 4'b1111});
    q1.push_back('{1'b0, 4'b1111});
    tick();
    chk("t6_gnt_a", {6'd0, gnt0, gnt1}, 8'b10);
    tick();
    tick();
    chk("t6_idle_gap", {6'd0, gnt0, busy}, 8'h00);
    tick();
    chk("t6_gnt_b", {6'd0, gnt0, gnt1}, 8'b10);
    tick();
    req0 = 0;
    tick();

    // reset mid-EXEC aborts the op; ptr returns to favour req0
    req1 = 1; a1 = 2'b10; b1 = 2'b10;
    tick();
    chk("t5_gnt1", {6'd0, gnt0, gnt1}, 8'b01);
    rst_n = 0;
    #1;
    chk("t5_abort_outs", {gnt0, gnt1, done0, done1, busy, 3'b0}, 8'h00);
    chk("t5_abort_alu", {alu_a, alu_b, alu_sel, 2'b0}, 8'h00);
    req0 = 1; a0 = 2'b01; b0 = 2'b01;
    tick();
    rst_n = 1;
    q1.push_back('{1'b0, 4'b0101});
    q1.push_back('{1'b1, 4'b1010});
    tick();
    chk("t5_gnt0_first", {6'd0, gnt0, gnt1}, 8'b10);
    tick();
    req0 = 0;
    tick();
    tick();
    chk("t5_gnt1_next", {6'd0, gnt0, gnt1}, 8'b01);
    tick();
    req1 = 0;
    tick();

    // ALU_LAT = 3: done exactly three cycles after gnt, operands frozen
    r3_req1 = 1; r3_a1 = 2'b01; r3_b1 = 2'b01; r3_sel1 = 2'b11;
    q3.push_back('{1'b1, 4'b0101});
    tick();
    chk("t4_gnt1", {6'd0, r3_gnt0, r3_gnt1}, 8'b01);
    chk("t4_sel", {6'd0, r3_alu_sel}, 8'h03);
    r3_a1 = 2'b10;
    tick();
    chk("t4_wait1", {6'd0, r3_done1, r3_busy}, 8'b01);
    chk("t4_alu_a_held", {6'd0, r3_alu_a}, 8'h01);
    tick();
    chk("t4_wait2", {6'd0, r3_done1, r3_busy}, 8'b01);
    tick();
    chk("t4_done1", {6'd0, r3_done0, r3_done1}, 8'b01);
    r3_req1 = 0;
    tick();
    tick();

    chk("q1_drained", 8'(q1.size()), 8'd0);
    chk("q3_drained", 8'(q3.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected end of stimulus");
    $fatal(1);
  end

endmodule
